mem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single CPU memory port (memop / memaddress / memoutdata / memindata) between the instruction-fetch path and the load/store path.
- Accepts one request at a time and drives the memory port for a fixed number of cycles.
- Returns read data, or a write-completion strobe, to the requester that was granted.
- Sits between the core's fetch/execute sequencer and the memory model.

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: fetch and load/store share one memory port.
// One access at a time. Ties alternate, and the first tie after reset goes to data.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RESP_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [31:0]       memop,
    output logic [31:0]       memaddress,
    output logic [31:0]       memoutdata,
    input  logic [31:0]       memindata
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic       OWN_FETCH = 1'b0;
    localparam logic       OWN_DATA  = 1'b1;
    localparam logic [3:0] CNT_INIT  = 4'(RESP_LAT - 1);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              owner_q;
    logic              last_grant_q;
    logic [31:0]       memop_q;
    logic [31:0]       memaddress_q;
    logic [31:0]       memoutdata_q;
    logic              i_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              fetch_win;
    logic              data_win;

    // Grant decision: only in IDLE; on a tie the requester not served last wins
    always_comb begin
        fetch_win = 1'b0;
        data_win  = 1'b0;
        if (state_q == IDLE) begin
            if (i_req && d_req) begin
                if (last_grant_q == OWN_FETCH) begin
                    data_win = 1'b1;
                end else begin
                    fetch_win = 1'b1;
                end
            end else begin
                fetch_win = i_req;
                data_win  = d_req;
            end
        end else begin
            fetch_win = 1'b0;
            data_win  = 1'b0;
        end
    end

    assign i_ack      = fetch_win;
    assign d_ack      = data_win;
    assign memop      = memop_q;
    assign memaddress = memaddress_q;
    assign memoutdata = memoutdata_q;
    assign i_rvalid   = i_rvalid_q;
    assign d_rvalid   = d_rvalid_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;

    // Arbiter FSM with registered memory-port and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= OWN_FETCH;
            last_grant_q <= OWN_FETCH;
            memop_q      <= 32'd0;
            memaddress_q <= 32'd0;
            memoutdata_q <= 32'd0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_rdata_q    <= {DATA_W{1'b0}};
            d_rdata_q    <= {DATA_W{1'b0}};
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fetch_win) begin
                        owner_q      <= OWN_FETCH;
                        last_grant_q <= OWN_FETCH;
                        memaddress_q <= 32'(i_addr);
                        memop_q      <= 32'd1;
                        cnt_q        <= CNT_INIT;
                        state_q      <= ACCESS;
                    end else if (data_win) begin
                        owner_q      <= OWN_DATA;
                        last_grant_q <= OWN_DATA;
                        memaddress_q <= 32'(d_addr);
                        memop_q      <= d_we ? 32'd2 : 32'd1;
                        if (d_we) begin
                            memoutdata_q <= 32'(d_wdata);
                        end
                        cnt_q        <= CNT_INIT;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // Final memop cycle: memindata is valid now
                        memop_q <= 32'd0;
                        state_q <= IDLE;
                        if (owner_q == OWN_DATA) begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= (memop_q == 32'd2) ? {DATA_W{1'b0}}
                                                             : memindata[DATA_W-1:0];
                        end else begin
                            i_rvalid_q <= 1'b1;
                            i_rdata_q  <= memindata[DATA_W-1:0];
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    memop_q <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. A table drives the RESP_LAT=1 instance cycle by cycle.
// Hand-written sequences cover the RESP_LAT=3 instance.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // RESP_LAT = 1 instance
    logic        rst1, ir1, dr1, dw1, ia1_ack, da1_ack, iv1, dv1;
    logic [31:0] ia1, da1, dwd1, mi1, ird1, drd1, op1, addr1, out1;

    // RESP_LAT = 3 instance
    logic        rst3, ir3, dr3, dw3, ia3_ack, da3_ack, iv3, dv3;
    logic [31:0] ia3, da3, dwd3, mi3, ird3, drd3, op3, addr3, out3;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RESP_LAT(1)) u1 (
        .clk(clk), .rst(rst1),
        .i_req(ir1), .i_addr(ia1), .i_ack(ia1_ack), .i_rvalid(iv1), .i_rdata(ird1),
        .d_req(dr1), .d_we(dw1), .d_addr(da1), .d_wdata(dwd1), .d_ack(da1_ack),
        .d_rvalid(dv1), .d_rdata(drd1),
        .memop(op1), .memaddress(addr1), .memoutdata(out1), .memindata(mi1)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RESP_LAT(3)) u3 (
        .clk(clk), .rst(rst3),
        .i_req(ir3), .i_addr(ia3), .i_ack(ia3_ack), .i_rvalid(iv3), .i_rdata(ird3),
        .d_req(dr3), .d_we(dw3), .d_addr(da3), .d_wdata(dwd3), .d_ack(da3_ack),
        .d_rvalid(dv3), .d_rdata(drd3),
        .memop(op3), .memaddress(addr3), .memoutdata(out3), .memindata(mi3)
    );

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] mi;
        logic        eia;
        logic        eda;
        logic        eiv;
        logic        edv;
        logic [31:0] eop;
        logic [31:0] eaddr;
        logic [31:0] eout;
        logic [31:0] eird;
        logic [31:0] edrd;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                                input logic [31:0] mi, input logic eia, input logic eda,
                                input logic eiv, input logic edv, input logic [31:0] eop,
                                input logic [31:0] eaddr, input logic [31:0] eout,
                                input logic [31:0] eird, input logic [31:0] edrd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.mi = mi;
        v.eia = eia; v.eda = eda; v.eiv = eiv; v.edv = edv; v.eop = eop;
        v.eaddr = eaddr; v.eout = eout; v.eird = eird; v.edrd = edrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;

    initial begin
        // Row = one cycle: inputs, then expected acks/rvalids/memop/memaddress/memoutdata/rdata
        tbl[0]  = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0,    32'h0, 32'h0,        32'h0);
        tbl[1]  = mk(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0,    32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0,    32'h0, 32'h0,        32'h0);
        tbl[2]  = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,  32'h20080005, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'h1000, 32'h0, 32'h0,        32'h0);
        tbl[3]  = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h1000, 32'h0, 32'h20080005, 32'h0);
        tbl[4]  = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h40,   DB,     32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1000, 32'h0, 32'h20080005, 32'h0);
        tbl[5]  = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 32'h40,   DB,    32'h20080005, 32'h0);
        tbl[6]  = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h40,   DB,    32'h20080005, 32'h0);
        tbl[7]  = mk(1'b1, 32'h2000, 1'b1, 1'b0, 32'h3000, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h40,   DB,    32'h20080005, 32'h0);
        tbl[8]  = mk(1'b1, 32'h2000, 1'b1, 1'b0, 32'h3000, 32'h0,  32'hA1,       1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'h2000, DB,    32'h20080005, 32'h0);
        tbl[9]  = mk(1'b1, 32'h2000, 1'b1, 1'b0, 32'h3000, 32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h2000, DB,    32'hA1,       32'h0);
        tbl[10] = mk(1'b1, 32'h2000, 1'b1, 1'b0, 32'h3000, 32'h0,  32'hB2,       1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'h3000, DB,    32'hA1,       32'h0);
        tbl[11] = mk(1'b1, 32'h2000, 1'b1, 1'b0, 32'h3000, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'h3000, DB,    32'hA1,       32'hB2);
        tbl[12] = mk(1'b1, 32'h2000, 1'b1, 1'b0, 32'h3000, 32'h0,  32'hC3,       1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'h2000, DB,    32'hA1,       32'hB2);
        tbl[13] = mk(1'b1, 32'h2000, 1'b1, 1'b0, 32'h3000, 32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h2000, DB,    32'hC3,       32'hB2);
        tbl[14] = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,  32'hD4,       1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'h3000, DB,    32'hC3,       32'hB2);
        tbl[15] = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h3000, DB,    32'hC3,       32'hD4);
        tbl[16] = mk(1'b1, 32'h500,  1'b0, 1'b0, 32'h0,    32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h3000, DB,    32'hC3,       32'hD4);
        tbl[17] = mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h600,  32'h0,  32'hE5,       1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'h500,  DB,    32'hC3,       32'hD4);
        tbl[18] = mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h600,  32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h500,  DB,    32'hE5,       32'hD4);
        tbl[19] = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,  32'hF6,       1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'h600,  DB,    32'hE5,       32'hD4);
        tbl[20] = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h600,  DB,    32'hE5,       32'hF6);

        rst1 = 1'b1; ir1 = 1'b0; ia1 = 32'h0; dr1 = 1'b0; dw1 = 1'b0; da1 = 32'h0; dwd1 = 32'h0; mi1 = 32'h0;
        rst3 = 1'b1; ir3 = 1'b0; ia3 = 32'h0; dr3 = 1'b0; dw3 = 1'b0; da3 = 32'h0; dwd3 = 32'h0; mi3 = 32'h0;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        rst3 = 1'b0;

        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            ir1 = tbl[k].ir; ia1 = tbl[k].ia; dr1 = tbl[k].dr; dw1 = tbl[k].dw;
            da1 = tbl[k].da; dwd1 = tbl[k].dwd; mi1 = tbl[k].mi;
            #1;
            chk($sformatf("r%0d i_ack", k),      {31'd0, ia1_ack}, {31'd0, tbl[k].eia});
            chk($sformatf("r%0d d_ack", k),      {31'd0, da1_ack}, {31'd0, tbl[k].eda});
            chk($sformatf("r%0d i_rvalid", k),   {31'd0, iv1},     {31'd0, tbl[k].eiv});
            chk($sformatf("r%0d d_rvalid", k),   {31'd0, dv1},     {31'd0, tbl[k].edv});
            chk($sformatf("r%0d memop", k),      op1,   tbl[k].eop);
            chk($sformatf("r%0d memaddress", k), addr1, tbl[k].eaddr);
            chk($sformatf("r%0d memoutdata", k), out1,  tbl[k].eout);
            chk($sformatf("r%0d i_rdata", k),    ird1,  tbl[k].eird);
            chk($sformatf("r%0d d_rdata", k),    drd1,  tbl[k].edrd);
        end

        // RESP_LAT=3 read: memop held three cycles, only the last memindata counts
        @(negedge clk);
        dr3 = 1'b1; dw3 = 1'b0; da3 = 32'h80;
        #1;
        chk("lat3 reset memop", op3, 32'd0);
        chk("lat3 d_ack", {31'd0, da3_ack}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            dr3 = 1'b0;
            mi3 = (c == 3) ? 32'h12345678 : 32'hBAD00000 + 32'(c);
            #1;
            chk($sformatf("lat3 c%0d memop", c), op3, 32'd1);
            chk($sformatf("lat3 c%0d memaddress", c), addr3, 32'h80);
            chk($sformatf("lat3 c%0d d_rvalid", c), {31'd0, dv3}, 32'd0);
        end
        @(negedge clk);
        mi3 = 32'h0;
        #1;
        chk("lat3 d_rvalid", {31'd0, dv3}, 32'd1);
        chk("lat3 d_rdata", drd3, 32'h12345678);
        chk("lat3 memop idle", op3, 32'd0);
        chk("lat3 i_rvalid", {31'd0, iv3}, 32'd0);
        @(negedge clk);
        #1;
        chk("lat3 d_rvalid drop", {31'd0, dv3}, 32'd0);
        chk("lat3 d_rdata hold", drd3, 32'h12345678);

        // Reset in the second memop cycle abandons the fetch access
        @(negedge clk);
        ir3 = 1'b1; ia3 = 32'h900;
        #1;
        chk("rst3 i_ack", {31'd0, ia3_ack}, 32'd1);
        @(negedge clk);
        ir3 = 1'b0;
        #1;
        chk("rst3 memop c1", op3, 32'd1);
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        chk("rst3 memop c2", op3, 32'd1);
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        chk("rst3 memop after", op3, 32'd0);
        chk("rst3 memaddress after", addr3, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rst3 no i_rvalid %0d", c), {31'd0, iv3}, 32'd0);
        end
        @(negedge clk);
        ir3 = 1'b1; ia3 = 32'hA00; dr3 = 1'b1; dw3 = 1'b0; da3 = 32'hB00;
        #1;
        chk("rst3 tie d_ack", {31'd0, da3_ack}, 32'd1);
        chk("rst3 tie i_ack", {31'd0, ia3_ack}, 32'd0);
        @(negedge clk);
        ir3 = 1'b0; dr3 = 1'b0;
        #1;
        chk("rst3 tie memaddress", addr3, 32'hB00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
